md_sched: RTL and testbench

Multiply/divide scheduler for the P6 pipeline. It sits beside the E-stage ALU and accepts one HI/LO operation per issue from E. It holds the HI/LO registers, runs a fixed-latency busy countdown for mult/div, and commits results at the end of that countdown. It also raises the D-stage stall request that the hazard unit ORs into its global stall.

---
 rtl/md_sched.sv | 126 ++++++++++++
 tb/tb_md_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// HI/LO multiply/divide scheduler: fixed-latency busy countdown, commit at end, D-stage stall request.
// Ops accepted only in IDLE; anything presented while BUSY is dropped.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  md_op_E,
  input  logic [31:0] rs_E,
  input  logic [31:0] rt_E,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   p_hi, p_lo, p_hi_n, p_lo_n;

  // Arithmetic datapath, evaluated every cycle from the E-stage operands
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        abs_rs, abs_rt, dvs_s, q_mag, r_mag, q_s, r_s;
  logic [31:0]        dvs_u, q_u, r_u;
  logic [63:0]        result;
  logic               op_md;

  always_comb begin
    prod_s = $signed({{32{rs_E[31]}}, rs_E}) * $signed({{32{rt_E[31]}}, rt_E});
    prod_u = {32'd0, rs_E} * {32'd0, rt_E};

    abs_rs = rs_E[31] ? (~rs_E + 32'd1) : rs_E;
    abs_rt = rt_E[31] ? (~rt_E + 32'd1) : rt_E;
    // Divisor forced to 1 on divide-by-zero; that result is discarded anyway
    dvs_s  = (rt_E == 32'd0) ? 32'd1 : abs_rt;
    q_mag  = abs_rs / dvs_s;
    r_mag  = abs_rs % dvs_s;
    q_s    = (rs_E[31] ^ rt_E[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = rs_E[31] ? (~r_mag + 32'd1) : r_mag;

    dvs_u  = (rt_E == 32'd0) ? 32'd1 : rt_E;
    q_u    = rs_E / dvs_u;
    r_u    = rs_E % dvs_u;

    result = 64'd0;
    case (md_op_E)
      3'd1:    result = prod_s;
      3'd2:    result = prod_u;
      // HI/LO cannot change while BUSY, so re-committing them leaves them unchanged
      3'd3:    result = (rt_E == 32'd0) ? {hi, lo} : {r_s, q_s};
      3'd4:    result = (rt_E == 32'd0) ? {hi, lo} : {r_u, q_u};
      default: result = 64'd0;
    endcase
  end

  assign op_md    = (md_op_E >= 3'd1) && (md_op_E <= 3'd4);
  assign busy     = (state == BUSY);
  assign stall_md = md_use_D & (busy | op_md);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    lo_n    = lo;
    p_hi_n  = p_hi;
    p_lo_n  = p_lo;
    case (state)
      IDLE: begin
        case (md_op_E)
          3'd1, 3'd2: begin
            {p_hi_n, p_lo_n} = result;
            cnt_n            = CW'(MULT_CYCLES);
            state_n          = BUSY;
          end
          3'd3, 3'd4: begin
            {p_hi_n, p_lo_n} = result;
            cnt_n            = CW'(DIV_CYCLES);
            state_n          = BUSY;
          end
          3'd5:    hi_n = rs_E;
          3'd6:    lo_n = rs_E;
          default: ;
        endcase
      end
      BUSY: begin
        if (cnt > CW'(1)) begin
          cnt_n = cnt - CW'(1);
        end else begin
          hi_n    = p_hi;
          lo_n    = p_lo;
          cnt_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi    <= hi_n;
      lo    <= lo_n;
      p_hi  <= p_hi_n;
      p_lo  <= p_lo_n;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: table of mult/div vectors with a result scoreboard, plus hand-written reset/mthi/stall sequences.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  md_op_E;
  logic [31:0] rs_E, rt_E;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_E(rs_E), .rt_E(rt_E),
    .md_use_D(md_use_D), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs, rt;
    int          cyc;
    logic [31:0] ehi, elo;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [31:0] ehi, elo;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op in the current cycle, follows it through busy, and scores the commit.
  // Returns at the negedge of the first cycle with busy=0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int cyc, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic use_d, input logic inject);
    logic [63:0] old;
    logic        hold_ok, stall_ok, done;
    int          n;
    exp_t        e;
    md_op_E  = op;
    rs_E     = rs;
    rt_E     = rt;
    md_use_D = use_d;
    sb.push_back('{cyc, ehi, elo});
    #1;
    check("issue_busy", busy, 1'b0);
    if (use_d) check("issue_stall", stall_md, 1'b1);
    old      = {hi, lo};
    hold_ok  = 1'b1;
    stall_ok = 1'b1;
    done     = 1'b0;
    n        = 0;
    @(posedge clk);
    #1;
    md_op_E = 3'd0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
      end else begin
        n++;
        if ({hi, lo} !== old) hold_ok = 1'b0;
        if (stall_md !== use_d) stall_ok = 1'b0;
        @(posedge clk);
        #1;
        md_op_E = (inject && n == 2) ? 3'd3 : 3'd0;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy still high after 40 cycles, required drop after %0d", cyc);
    end
    e = sb.pop_front();
    check("busy_cycles", n, e.cyc);
    check("hi", hi, e.ehi);
    check("lo", lo, e.elo);
    check("hold_during_busy", hold_ok, 1'b1);
    check("stall_during_busy", stall_ok, 1'b1);
    if (use_d) check("stall_at_drop", stall_md, 1'b0);
  endtask

  initial begin
    vecs[0] = '{3'd1, 32'hFFFFFFFD, 32'd4,          5,  32'hFFFFFFFF, 32'hFFFFFFF4};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,   5,  32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,          10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 32'd7,        32'd2,          10, 32'd1,        32'd3};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   10, 32'd0,        32'h80000000};
    vecs[5] = '{3'd1, 32'h00010000, 32'h00010000,   5,  32'd1,        32'd0};
    vecs[6] = '{3'd3, 32'd7,        32'hFFFFFFFE,   10, 32'd1,        32'hFFFFFFFD};
    vecs[7] = '{3'd4, 32'hFFFFFFFF, 32'd10,         10, 32'd5,        32'h19999999};

    reset    = 1'b1;
    md_op_E  = 3'd0;
    rs_E     = 32'd0;
    rt_E     = 32'd0;
    md_use_D = 1'b0;
    repeat (3) step();
    check("reset_busy", busy, 1'b0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_stall", stall_md, 1'b0);
    reset    = 1'b0;
    md_use_D = 1'b1;
    #1;
    check("idle_use_no_stall", stall_md, 1'b0);
    step();

    // Vectors run back-to-back: each new op issues in the first idle cycle
    for (int i = 0; i < 8; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].cyc, vecs[i].ehi, vecs[i].elo, 1'b1, 1'b0);

    // Div issued mid-busy is ignored; md_use_D=0 keeps stall low
    step();
    run_op(3'd1, 32'd6, 32'd7, 5, 32'd0, 32'd42, 1'b0, 1'b1);

    // Reserved op does nothing
    step();
    md_op_E = 3'd7;
    step();
    md_op_E = 3'd0;
    check("reserved_no_busy", busy, 1'b0);
    check("reserved_hi", hi, 32'd0);
    check("reserved_lo", lo, 32'd42);

    // mthi/mtlo, then divide by zero leaves HI/LO untouched
    md_op_E = 3'd5;
    rs_E    = 32'h11;
    step();
    check("mthi_hi", hi, 32'h11);
    check("mthi_busy", busy, 1'b0);
    md_op_E = 3'd6;
    rs_E    = 32'h22;
    step();
    md_op_E = 3'd0;
    check("mtlo_lo", lo, 32'h22);
    check("mtlo_hi_kept", hi, 32'h11);
    step();
    run_op(3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b1, 1'b0);

    // Reset at busy cycle 3 of a div discards the pending result
    step();
    md_use_D = 1'b0;
    md_op_E  = 3'd3;
    rs_E     = 32'd100;
    rt_E     = 32'd7;
    step();
    md_op_E = 3'd0;
    step();
    step();
    check("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_busy", busy, 1'b0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);
    repeat (12) step();
    check("no_late_commit_hi", hi, 32'd0);
    check("no_late_commit_lo", lo, 32'd0);
    check("no_late_busy", busy, 1'b0);

    md_op_E = 3'd5;
    rs_E    = 32'hABCD;
    step();
    md_op_E = 3'd0;
    check("mthi_abcd", hi, 32'hABCD);
    check("mthi_abcd_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
